// File: rtl/detector_jogada_if.sv
// Play-detector bus: raw buttons and enable in, debounced play and debug state out.
// The control unit side is the master; the detector is the slave.
interface detector_jogada_if;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  modport master (
    output habilita,
    output chaves,
    input  jogada,
    input  jogada_feita,
    input  jogada_invalida,
    input  db_estado
  );

  modport slave (
    input  habilita,
    input  chaves,
    output jogada,
    output jogada_feita,
    output jogada_invalida,
    output db_estado
  );
endinterface

// File: rtl/detector_jogada.sv
// Input stage for the exp3 game: synchronizes and debounces the four button
// lines and turns each stable one-hot press into a single registered play with
// a one-cycle strobe. Non-one-hot presses raise a one-cycle invalid strobe and
// never reach the play register. A debounced release is required between plays.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic               clock,
  input logic               reset,
  detector_jogada_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    ESPERA     = 3'd1,
    ESTABILIZA = 3'd2,
    REGISTRA   = 3'd3,
    SOLTAR     = 3'd4
  } estado_t;

  estado_t          r_state;
  estado_t          w_nextState;
  logic [3:0]       r_sinc1;
  logic [3:0]       r_sinc2;
  logic [3:0]       r_cand;
  logic [3:0]       w_candNext;
  logic [3:0]       r_jogada;
  logic [3:0]       w_jogadaNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_candOneHot;

  assign w_candOneHot = (r_cand != 4'd0) && ((r_cand & (r_cand - 4'd1)) == 4'd0);

  // Two-flop synchronizer: the FSM only ever looks at r_sinc2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sinc1 <= 4'd0;
      r_sinc2 <= 4'd0;
    end else begin
      r_sinc1 <= bus.chaves;
      r_sinc2 <= r_sinc1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= INICIAL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state, counter, candidate and play-register update rules.
  always_comb begin
    w_nextState  = r_state;
    w_cntNext    = r_cnt;
    w_candNext   = r_cand;
    w_jogadaNext = r_jogada;
    case (r_state)
      INICIAL: begin
        if (bus.habilita) w_nextState = ESPERA;
      end
      ESPERA: begin
        if (!bus.habilita) begin
          w_nextState = INICIAL;
        end else if (r_sinc2 != 4'd0) begin
          w_candNext  = r_sinc2;
          w_nextState = ESTABILIZA;
        end
      end
      ESTABILIZA: begin
        if (!bus.habilita) begin
          w_nextState = INICIAL;
        end else if (r_sinc2 != r_cand) begin
          w_nextState = ESPERA;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = REGISTRA;
          if (w_candOneHot) w_jogadaNext = r_cand;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      REGISTRA: begin
        w_nextState = SOLTAR;
      end
      SOLTAR: begin
        if (r_sinc2 != 4'd0) begin
          w_cntNext = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = bus.habilita ? ESPERA : INICIAL;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextState = INICIAL;
      end
    endcase
    if (w_nextState != r_state) w_cntNext = '0;
  end

  // Datapath registers: debounce counter, press candidate and the play itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_cand   <= 4'd0;
      r_jogada <= 4'd0;
    end else begin
      r_cnt    <= w_cntNext;
      r_cand   <= w_candNext;
      r_jogada <= w_jogadaNext;
    end
  end

  assign bus.jogada          = r_jogada;
  assign bus.jogada_feita    = (r_state == REGISTRA) && w_candOneHot;
  assign bus.jogada_invalida = (r_state == REGISTRA) && !w_candOneHot;
  assign bus.db_estado       = r_state;

endmodule
